// File: rtl/channel_sweep_control_pkg.sv
// Shared constants, state encoding and word-packing helper for the channel sweep controller.
package channel_sweep_control_pkg;

  localparam int CHANNEL_WIDTH = 6;
  localparam int DATA_WIDTH    = 16;
  localparam int TAG_WIDTH     = DATA_WIDTH - CHANNEL_WIDTH;

  localparam logic [TAG_WIDTH-1:0] HEADER_TAG_DEFAULT     = 10'h3C5;
  localparam logic [TAG_WIDTH-1:0] TAIL_TAG_DEFAULT       = 10'h3A5;
  localparam int                   CONFIG_TIMEOUT_DEFAULT = 50000;

  typedef logic [2:0] sweepState_t;

  localparam sweepState_t IDLE        = 3'd0;
  localparam sweepState_t LOAD_MASK   = 3'd1;
  localparam sweepState_t WAIT_CONFIG = 3'd2;
  localparam sweepState_t HEADER      = 3'd3;
  localparam sweepState_t START_SWEEP = 3'd4;
  localparam sweepState_t WAIT_ACQ    = 3'd5;
  localparam sweepState_t TAIL        = 3'd6;
  localparam sweepState_t NEXT        = 3'd7;

  // Header and tail words carry the tag in the upper bits and the channel in the lower bits.
  function automatic logic [DATA_WIDTH-1:0] tagWord(input logic [TAG_WIDTH-1:0] tag,
                                                    input logic [CHANNEL_WIDTH-1:0] channel);
    return {tag, channel};
  endfunction

endpackage

// File: rtl/config_timeout_counter.sv
// Counts cycles spent waiting for slow-control configuration; expired flags the last allowed cycle.
module config_timeout_counter #(
  parameter int LIMIT = 50000
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  // Holds at LAST so an un-serviced enable never wraps back to a fresh window.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/channel_sweep_control.sv
// Steps through a channel range: loads each channel mask, runs one DAC sweep, and frames the data.
module channel_sweep_control
  import channel_sweep_control_pkg::*;
#(
  parameter logic [TAG_WIDTH-1:0] HEADER_TAG     = HEADER_TAG_DEFAULT,
  parameter logic [TAG_WIDTH-1:0] TAIL_TAG       = TAIL_TAG_DEFAULT,
  parameter int                   CONFIG_TIMEOUT = CONFIG_TIMEOUT_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic [CHANNEL_WIDTH-1:0] StartChannel,
  input  logic [CHANNEL_WIDTH-1:0] EndChannel,
  output logic [CHANNEL_WIDTH-1:0] OutChannel,
  output logic                     LoadChannelMask,
  input  logic                     MicrorocConfigDone,
  output logic                     SweepStart,
  input  logic                     ACQDone,
  input  logic [DATA_WIDTH-1:0]    SweepACQData,
  input  logic                     SweepACQData_en,
  output logic [DATA_WIDTH-1:0]    OutData,
  output logic                     OutData_en,
  input  logic                     OutFull,
  output logic                     Busy,
  output logic                     AllDone,
  output logic                     ConfigTimeout,
  output logic                     Overflow,
  output sweepState_t              DebugState
);

  // Output stream: OutData is valid in every cycle OutData_en is high; OutFull acts as
  // ready for header/tail words only. Sweep data is never held back, so a word leaving
  // while OutFull is high is flagged through Overflow instead of being stalled.

  sweepState_t              state;
  sweepState_t              stateNext;
  logic [CHANNEL_WIDTH-1:0] channel;
  logic [CHANNEL_WIDTH-1:0] channelNext;
  logic [CHANNEL_WIDTH-1:0] endLatched;
  logic                     timerClear;
  logic                     timerEnable;
  logic                     timerExpired;
  logic                     aborting;

  assign aborting = Stop && (state != IDLE);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:        if (Start && (StartChannel <= EndChannel)) stateNext = LOAD_MASK;
      LOAD_MASK:   stateNext = WAIT_CONFIG;
      WAIT_CONFIG: begin
        if (MicrorocConfigDone)    stateNext = HEADER;
        else if (timerExpired)     stateNext = IDLE;
      end
      HEADER:      if (!OutFull) stateNext = START_SWEEP;
      START_SWEEP: stateNext = WAIT_ACQ;
      WAIT_ACQ:    if (ACQDone) stateNext = TAIL;
      TAIL:        if (!OutFull) stateNext = NEXT;
      NEXT:        stateNext = (channel == endLatched) ? IDLE : LOAD_MASK;
      default:     stateNext = IDLE;
    endcase
    if (aborting) stateNext = IDLE;
  end

  // The end comparison happens before the increment, so a range ending at 63 never wraps.
  always_comb begin
    channelNext = channel;
    if ((state == IDLE) && Start) begin
      channelNext = StartChannel;
    end else if ((state == NEXT) && !aborting && (channel != endLatched)) begin
      channelNext = channel + 1'b1;
    end
  end

  // The window opens on entry to LOAD_MASK so expiry lands CONFIG_TIMEOUT cycles after the load pulse.
  assign timerClear  = (stateNext == LOAD_MASK);
  assign timerEnable = (state == LOAD_MASK) || (state == WAIT_CONFIG);

  config_timeout_counter #(
    .LIMIT (CONFIG_TIMEOUT)
  ) u_timeout (
    .Clk     (Clk),
    .reset_n (reset_n),
    .clear   (timerClear),
    .enable  (timerEnable),
    .expired (timerExpired)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      channel       <= '0;
      endLatched    <= '0;
      OutChannel    <= '0;
      OutData       <= '0;
      OutData_en    <= 1'b0;
      AllDone       <= 1'b0;
      ConfigTimeout <= 1'b0;
      Overflow      <= 1'b0;
    end else begin
      state      <= stateNext;
      channel    <= channelNext;
      OutData_en <= 1'b0;
      AllDone    <= 1'b0;
      if (stateNext == LOAD_MASK) OutChannel <= channelNext;
      case (state)
        IDLE: begin
          if (Start) begin
            endLatched    <= EndChannel;
            ConfigTimeout <= 1'b0;
            Overflow      <= 1'b0;
            if (StartChannel > EndChannel) AllDone <= 1'b1;
          end
        end
        WAIT_CONFIG: begin
          if (!aborting && !MicrorocConfigDone && timerExpired) ConfigTimeout <= 1'b1;
        end
        HEADER: begin
          if (!aborting && !OutFull) begin
            OutData    <= tagWord(HEADER_TAG, channel);
            OutData_en <= 1'b1;
          end
        end
        // A word arriving alongside Stop or ACQDone is still forwarded.
        WAIT_ACQ: begin
          if (SweepACQData_en) begin
            OutData    <= SweepACQData;
            OutData_en <= 1'b1;
            if (OutFull) Overflow <= 1'b1;
          end
        end
        TAIL: begin
          if (!aborting && !OutFull) begin
            OutData    <= tagWord(TAIL_TAG, channel);
            OutData_en <= 1'b1;
          end
        end
        NEXT: begin
          if (!aborting && (channel == endLatched)) AllDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy            = (state != IDLE);
  assign LoadChannelMask = (state == LOAD_MASK);
  assign SweepStart      = (state == START_SWEEP);
  assign DebugState      = state;

endmodule

// File: tb/tb_channel_sweep_control.sv
// Directed bench for channel_sweep_control: scan table plus timeout, back-pressure, stop and reset sequences.
module tb_channel_sweep_control;
  import channel_sweep_control_pkg::*;

  localparam int CT = 64;
  localparam logic [9:0] HDR = 10'h3C5;
  localparam logic [9:0] TL  = 10'h3A5;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Stop = 1'b0;
  logic [5:0]  StartChannel = '0;
  logic [5:0]  EndChannel = '0;
  logic [5:0]  OutChannel;
  logic        LoadChannelMask;
  logic        MicrorocConfigDone;
  logic        SweepStart;
  logic        ACQDone;
  logic [15:0] SweepACQData;
  logic        SweepACQData_en;
  logic [15:0] OutData;
  logic        OutData_en;
  logic        OutFull = 1'b0;
  logic        Busy;
  logic        AllDone;
  logic        ConfigTimeout;
  logic        Overflow;
  sweepState_t DebugState;

  channel_sweep_control #(.CONFIG_TIMEOUT(CT)) dut (
    .Clk(Clk), .reset_n(reset_n), .Start(Start), .Stop(Stop),
    .StartChannel(StartChannel), .EndChannel(EndChannel), .OutChannel(OutChannel),
    .LoadChannelMask(LoadChannelMask), .MicrorocConfigDone(MicrorocConfigDone),
    .SweepStart(SweepStart), .ACQDone(ACQDone), .SweepACQData(SweepACQData),
    .SweepACQData_en(SweepACQData_en), .OutData(OutData), .OutData_en(OutData_en),
    .OutFull(OutFull), .Busy(Busy), .AllDone(AllDone), .ConfigTimeout(ConfigTimeout),
    .Overflow(Overflow), .DebugState(DebugState)
  );

  // Clock and reset
  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Output monitor
  logic [15:0] gotMem [0:1023];
  int gotCount = 0;
  int nLoad = 0;
  int nSweep = 0;
  int nAllDone = 0;

  always @(negedge Clk) begin
    if (OutData_en) begin
      gotMem[gotCount[9:0]] <= OutData;
      gotCount <= gotCount + 1;
    end
    if (LoadChannelMask) nLoad <= nLoad + 1;
    if (SweepStart) nSweep <= nSweep + 1;
    if (AllDone) nAllDone <= nAllDone + 1;
  end

  // Front-end responder: config done cfgDelay cycles after each load, then words + ACQDone per sweep
  logic       cfgEnable = 1'b1;
  int         cfgDelay = 10;
  int         wordsPerCh = 4;
  int         cfgCnt = 0;
  int         wordIdx = 0;
  logic       acqPending = 1'b0;
  logic [7:0] curSweep = '0;
  logic [7:0] sweepSeen = '0;
  logic [3:0] idx4;

  initial begin
    MicrorocConfigDone = 1'b0;
    ACQDone = 1'b0;
    SweepACQData = '0;
    SweepACQData_en = 1'b0;
    wordIdx = 4;
    forever begin
      @(negedge Clk);
      MicrorocConfigDone = 1'b0;
      SweepACQData_en = 1'b0;
      ACQDone = 1'b0;
      if (cfgCnt > 0) begin
        cfgCnt--;
        if (cfgCnt == 0) MicrorocConfigDone = 1'b1;
      end
      if (wordIdx < wordsPerCh) begin
        idx4 = wordIdx[3:0];
        SweepACQData = {4'hD, curSweep, idx4};
        SweepACQData_en = 1'b1;
        wordIdx++;
      end else if (acqPending) begin
        ACQDone = 1'b1;
        acqPending = 1'b0;
      end
      if (LoadChannelMask && cfgEnable) cfgCnt = cfgDelay;
      if (SweepStart) begin
        sweepSeen = sweepSeen + 8'd1;
        curSweep = sweepSeen;
        wordIdx = 0;
        acqPending = 1'b1;
      end
    end
  end

  // Scoreboard
  logic [15:0] exp_q[$];
  int rdIdx = 0;

  task automatic pushChannel(input int ch, input int words, input logic [7:0] sweepId,
                             input bit withTail, input int keepWords);
    logic [5:0] c6;
    logic [3:0] i4;
    c6 = 6'(ch);
    exp_q.push_back({HDR, c6});
    for (int i = 0; i < words && i < keepWords; i++) begin
      i4 = 4'(i);
      exp_q.push_back({4'hD, sweepId, i4});
    end
    if (withTail) exp_q.push_back({TL, c6});
  endtask

  task automatic checkStream(input string name);
    check({name, " word count"}, 32'(gotCount - rdIdx), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rdIdx + i < gotCount) check({name, " word"}, 32'(gotMem[rdIdx + i]), 32'(exp_q[i]));
    end
    rdIdx = gotCount;
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic pulseStart(input logic [5:0] s, input logic [5:0] e);
    StartChannel = s;
    EndChannel = e;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic waitAllDone(input string name, input int budget);
    int n = 0;
    while (!AllDone && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check({name, " AllDone seen"}, 32'(AllDone), 32'd1);
  endtask

  typedef struct {
    logic [5:0] startCh;
    logic [5:0] endCh;
    int         words;
    int         delay;
    int         expSweeps;
    int         expWords;
  } scanVec_t;

  scanVec_t vecs[6];

  initial begin
    int loads0, sweeps0, dones0, n, enSeen;
    logic [7:0] base;

    vecs[0] = '{6'd3,  6'd5,  4, 10,     3, 18};
    vecs[1] = '{6'd63, 6'd63, 2, 3,      1, 4};
    vecs[2] = '{6'd9,  6'd2,  4, 10,     0, 0};
    vecs[3] = '{6'd0,  6'd1,  0, 1,      2, 4};
    vecs[4] = '{6'd20, 6'd20, 1, CT - 1, 1, 3};
    vecs[5] = '{6'd62, 6'd63, 3, 5,      2, 10};

    // Reset state
    repeat (3) @(negedge Clk);
    check("rst Busy", 32'(Busy), 0);
    check("rst OutData_en", 32'(OutData_en), 0);
    check("rst OutData", 32'(OutData), 0);
    check("rst OutChannel", 32'(OutChannel), 0);
    check("rst flags", {29'd0, AllDone, ConfigTimeout, Overflow}, 0);
    check("rst pulses", {30'd0, LoadChannelMask, SweepStart}, 0);
    check("rst state", 32'(DebugState), 32'(IDLE));
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Configuration timeout
    cfgEnable = 1'b0;
    dones0 = nAllDone;
    pulseStart(6'd10, 6'd12);
    n = 0;
    while (!LoadChannelMask && n < 5) begin @(negedge Clk); n++; end
    check("to load seen", 32'(LoadChannelMask), 1);
    repeat (CT - 1) @(negedge Clk);
    check("to flag early", 32'(ConfigTimeout), 0);
    check("to busy early", 32'(Busy), 1);
    @(negedge Clk);
    check("to flag", 32'(ConfigTimeout), 1);
    check("to busy", 32'(Busy), 0);
    check("to state", 32'(DebugState), 32'(IDLE));
    repeat (5) @(negedge Clk);
    check("to sticky", 32'(ConfigTimeout), 1);
    check("to no AllDone", 32'(nAllDone - dones0), 0);
    checkStream("to stream");
    cfgEnable = 1'b1;

    // OutFull back-pressure on header and tail, overflow on data
    cfgDelay = 10;
    wordsPerCh = 4;
    base = sweepSeen;
    loads0 = nLoad;
    pulseStart(6'd7, 6'd7);
    check("of timeout cleared", 32'(ConfigTimeout), 0);
    repeat (10) @(negedge Clk);
    OutFull = 1'b1;
    StartChannel = 6'd0;
    EndChannel = 6'd0;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    enSeen = 0;
    repeat (19) begin
      if (OutData_en) enSeen++;
      @(negedge Clk);
    end
    OutFull = 1'b0;
    check("of held header", 32'(enSeen), 0);
    @(negedge Clk);
    check("of header en", 32'(OutData_en), 1);
    check("of header word", 32'(OutData), 32'({HDR, 6'd7}));
    check("of sweep start", 32'(SweepStart), 1);
    repeat (2) @(negedge Clk);
    OutFull = 1'b1;
    check("of overflow before", 32'(Overflow), 0);
    @(negedge Clk);
    OutFull = 1'b0;
    check("of overflow set", 32'(Overflow), 1);
    repeat (2) @(negedge Clk);
    OutFull = 1'b1;
    repeat (3) @(negedge Clk);
    OutFull = 1'b0;
    @(negedge Clk);
    check("of tail en", 32'(OutData_en), 1);
    check("of tail word", 32'(OutData), 32'({TL, 6'd7}));
    waitAllDone("of", 20);
    repeat (3) @(negedge Clk);
    check("of overflow sticky", 32'(Overflow), 1);
    check("of loads", 32'(nLoad - loads0), 1);
    pushChannel(7, 4, base + 8'd1, 1'b1, 4);
    checkStream("of stream");

    // Stop during WAIT_ACQ on channel 62 of 60..63
    cfgDelay = 2;
    base = sweepSeen;
    dones0 = nAllDone;
    pulseStart(6'd60, 6'd63);
    check("stop overflow cleared", 32'(Overflow), 0);
    n = 0;
    while (!(SweepStart && OutChannel == 6'd62) && n < 200) begin @(negedge Clk); n++; end
    check("stop ch62 sweep", 32'(SweepStart), 1);
    repeat (2) @(negedge Clk);
    Stop = 1'b1;
    @(negedge Clk);
    Stop = 1'b0;
    check("stop busy", 32'(Busy), 0);
    check("stop state", 32'(DebugState), 32'(IDLE));
    check("stop last word en", 32'(OutData_en), 1);
    repeat (15) @(negedge Clk);
    check("stop no AllDone", 32'(nAllDone - dones0), 0);
    pushChannel(60, 4, base + 8'd1, 1'b1, 4);
    pushChannel(61, 4, base + 8'd2, 1'b1, 4);
    pushChannel(62, 4, base + 8'd3, 1'b0, 2);
    checkStream("stop stream");

    // Asynchronous reset mid-scan
    pulseStart(6'd1, 6'd3);
    dones0 = nAllDone;
    n = 0;
    while (!SweepStart && n < 50) begin @(negedge Clk); n++; end
    check("rstmid sweep", 32'(SweepStart), 1);
    @(negedge Clk);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid busy", 32'(Busy), 0);
    check("rstmid outs", {15'd0, OutData_en, OutData}, 0);
    check("rstmid channel", 32'(OutChannel), 0);
    @(negedge Clk);
    reset_n = 1'b1;
    repeat (15) @(negedge Clk);
    check("rstmid stays idle", 32'(Busy), 0);
    check("rstmid no AllDone", 32'(nAllDone - dones0), 0);
    rdIdx = gotCount;

    // Scan table
    for (int v = 0; v < 6; v++) begin
      cfgDelay = vecs[v].delay;
      wordsPerCh = vecs[v].words;
      base = sweepSeen;
      loads0 = nLoad;
      sweeps0 = nSweep;
      dones0 = nAllDone;
      pulseStart(vecs[v].startCh, vecs[v].endCh);
      if (vecs[v].expSweeps == 0) begin
        check("tbl empty AllDone", 32'(AllDone), 1);
        check("tbl empty busy", 32'(Busy), 0);
        @(negedge Clk);
        check("tbl empty AllDone once", 32'(AllDone), 0);
      end else begin
        waitAllDone("tbl", 3000);
      end
      repeat (3) @(negedge Clk);
      check("tbl sweeps", 32'(nSweep - sweeps0), 32'(vecs[v].expSweeps));
      check("tbl loads", 32'(nLoad - loads0), 32'(vecs[v].expSweeps));
      check("tbl alldone", 32'(nAllDone - dones0), 1);
      check("tbl flags", {30'd0, ConfigTimeout, Overflow}, 0);
      if (vecs[v].startCh == 6'd63) check("tbl ch63 no wrap", 32'(OutChannel), 32'd63);
      for (int c = 0; c < vecs[v].expSweeps; c++) begin
        pushChannel(int'(vecs[v].startCh) + c, vecs[v].words, base + 8'(c + 1), 1'b1, vecs[v].words);
      end
      check("tbl model size", 32'(exp_q.size()), 32'(vecs[v].expWords));
      checkStream("tbl stream");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/channel_sweep_control.md
CHANNEL_SWEEP_CONTROL -- requirements
Module: channel_sweep_control

Interface
REQ-001 Parameter HEADER_TAG, default 10'h3C5: upper 10 bits of each per-channel header word.
REQ-002 Parameter TAIL_TAG, default 10'h3A5: upper 10 bits of each per-channel tail word.
REQ-003 Parameter CONFIG_TIMEOUT, default 50000: cycles allowed for MicrorocConfigDone after a mask load.
REQ-004 Ports (name, direction, width, meaning):
- Clk  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; begins a channel scan; honoured only in IDLE.
- Stop  in  1  one-cycle pulse; aborts the scan.
- StartChannel  in  6  first channel.
- EndChannel  in  6  last channel.
- OutChannel  out  6  channel under test, driven to the channel-mask configuration.
- LoadChannelMask  out  1  one-cycle pulse; requests slow-control reload.
- MicrorocConfigDone  in  1  pulse or level; configuration complete.
- SweepStart  out  1  one-cycle pulse; starts one DAC sweep.
- ACQDone  in  1  pulse; DAC sweep for the channel finished.
- SweepACQData  in  16  sweep data word.
- SweepACQData_en  in  1  qualifies SweepACQData.
- OutData  out  16  merged output stream.
- OutData_en  out  1  qualifies OutData.
- OutFull  in  1  downstream FIFO full.
- Busy  out  1  high in every state except IDLE.
- AllDone  out  1  one-cycle pulse on normal scan completion.
- ConfigTimeout  out  1  sticky flag; configuration timed out.
- Overflow  out  1  sticky flag; data forwarded while OutFull was high.

Function
REQ-005 States: IDLE, LOAD_MASK, WAIT_CONFIG, HEADER, START_SWEEP, WAIT_ACQ, TAIL, NEXT.
REQ-006 IDLE with Start:
- StartChannel and EndChannel are latched.
- Channel counter is loaded with StartChannel.
- ConfigTimeout and Overflow are cleared.
- If the latched StartChannel > EndChannel: AllDone pulses the next cycle, no other output activity, FSM stays in IDLE.
- Otherwise: go to LOAD_MASK.
REQ-007 LOAD_MASK (one cycle):
- OutChannel = channel counter; it stays stable until the next LOAD_MASK.
- LoadChannelMask = 1; timeout counter cleared; go to WAIT_CONFIG.
REQ-008 WAIT_CONFIG:
- MicrorocConfigDone = 1: go to HEADER.
- Timeout counter reaches CONFIG_TIMEOUT-1 first: set ConfigTimeout, go to IDLE, no AllDone.
- MicrorocConfigDone in the same cycle as timeout expiry counts as success.
REQ-009 HEADER:
- Wait while OutFull = 1.
- When OutFull = 0: emit OutData = {HEADER_TAG, channel}, OutData_en = 1 for exactly one cycle; go to START_SWEEP.
REQ-010 START_SWEEP (one cycle): SweepStart = 1; go to WAIT_ACQ.
REQ-011 WAIT_ACQ:
- Each SweepACQData_en cycle: OutData = SweepACQData, OutData_en = 1, registered, latency 1 cycle.
- Data is never stalled; a word forwarded while OutFull = 1 sets Overflow.
- ACQDone: go to TAIL.
- A data word in the same cycle as ACQDone is still forwarded, before the tail.
REQ-012 TAIL:
- Wait while OutFull = 0 is false.
- When OutFull = 0: emit {TAIL_TAG, channel} for one cycle; go to NEXT.
REQ-013 NEXT:
- Channel == EndChannel: pulse AllDone, go to IDLE.
- Otherwise: increment channel, go to LOAD_MASK.
- Comparison precedes increment, so EndChannel = 63 terminates without wrap-around.
REQ-014 OutData_en is never asserted in two sources in one cycle; at most one word per cycle.
REQ-015 Stop in any non-IDLE state:
- Next state is IDLE.
- No further header, tail, SweepStart or LoadChannelMask.
- No AllDone.
- A data word registered in that cycle is still output.
- Stop has priority over every other transition.
REQ-016 Start while Busy is ignored.
REQ-017 Sticky flags hold their value until the next accepted Start.

Reset
REQ-018 reset_n low asynchronously forces:
- FSM to IDLE.
- Channel counter, timeout counter and latched channel bounds to 0.
- OutChannel = 0, OutData = 0.
- LoadChannelMask, SweepStart, OutData_en, Busy, AllDone, ConfigTimeout, Overflow = 0.
REQ-019 Reset asserted mid-scan abandons the scan; after deassertion the block waits in IDLE for a new Start.

Structure
REQ-020 A shared package holds:
- the state enumeration;
- HEADER_TAG, TAIL_TAG and CONFIG_TIMEOUT defaults;
- the 6-bit channel width constant.
REQ-021 The timeout counter is one sub-module, config_timeout_counter: clear, enable, expired output. All other logic is in the top module.

Verification
REQ-022 StartChannel = 3, EndChannel = 5, config done 10 cycles after each load, 4 data words per channel, ACQDone after the last word. Required response:
- stream = header 16'hF143, 4 words, tail 16'hE943, repeated for channels 4 and 5;
- 3 SweepStart pulses;
- AllDone once.
REQ-023 MicrorocConfigDone never asserted. Required response:
- ConfigTimeout = 1 exactly CONFIG_TIMEOUT cycles after LoadChannelMask;
- FSM returns to IDLE;
- no header, no AllDone.
REQ-024 StartChannel = 9, EndChannel = 2 -> AllDone one cycle after Start; OutData_en, SweepStart and LoadChannelMask never asserted.
REQ-025 OutFull = 1 held 20 cycles entering HEADER -> header is emitted on the first cycle after OutFull falls; a data word forwarded with OutFull = 1 sets Overflow.
REQ-026 Stop in WAIT_ACQ on channel 62 of a 60..63 scan -> no tail, no AllDone, Busy = 0 next cycle; a subsequent Start runs normally.
REQ-027 StartChannel = EndChannel = 63 -> one header/tail pair with low bits 6'h3F, then AllDone; channel counter never wraps to 0 during the scan.
